// File: rtl/conv_enc_pkg.sv
// Shared types, constraint-length limits and generator tables for the convolutional frame encoder.
package conv_enc_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        ENCODE  = 2'd2,
        DRAIN   = 2'd3
    } state_t;

    localparam logic [2:0] K_MIN = 3'd3;
    localparam logic [2:0] K_MAX = 3'd6;

    // Octal generator taps per constraint length; bit K-1 multiplies the current input.
    localparam logic [5:0] G0 [K_MIN:K_MAX] = '{6'o07, 6'o17, 6'o35, 6'o75};
    localparam logic [5:0] G1 [K_MIN:K_MAX] = '{6'o05, 6'o15, 6'o23, 6'o53};

    function automatic logic [2:0] tail_len(input logic [2:0] k, input logic flush);
        return flush ? (k - 3'd1) : 3'd0;
    endfunction

endpackage

// File: rtl/conv_enc_core.sv
// Rate-1/2 encoder window: pair_nxt is the parity of the current bit, pair is its registered copy.
// One bit per enabled cycle; holds history and pair when en is low.
module conv_enc_core
    import conv_enc_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       en,
    input  logic [2:0] k,
    input  logic       bit_in,
    output logic [1:0] pair,
    output logic [1:0] pair_nxt
);

    logic [4:0] hist;
    logic [5:0] w;
    logic [2:0] km1;

    assign km1 = k - 3'd1;

    // hist[0] is the previous bit, hist[j] the bit j+1 steps back.
    always_comb begin
        w = '0;
        for (int i = 0; i < 6; i++) begin
            if (3'(i) == km1)
                w[i] = bit_in;
            else if (3'(i) < km1)
                w[i] = hist[km1 - 3'd1 - 3'(i)];
        end
    end

    assign pair_nxt = {^(w & G1[k]), ^(w & G0[k])};

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            hist <= '0;
            pair <= '0;
        end else if (en) begin
            hist <= {hist[3:0], bit_in};
            pair <= pair_nxt;
        end
    end

endmodule

// File: rtl/conv_frame_encoder.sv
// Buffers a frame from the UART receiver and streams its convolutional encoding, 4 input bits per output byte.
// First byte valid 4 cycles into ENCODE; the encoder stalls only when a completed byte finds the output register full.
module conv_frame_encoder
    import conv_enc_pkg::*;
#(
    parameter int FRAME_BYTES = 4,
    parameter bit TAIL_FLUSH  = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_valid,
    input  logic [7:0] rx_data,
    input  logic [2:0] k_sel,
    input  logic       abort,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic       busy,
    output logic       frame_done,
    output logic       k_err,
    output logic       rx_overrun
);

    localparam int FBW = 8 * FRAME_BYTES;

    state_t           state, state_nxt;
    logic [FBW-1:0]   frame_q;
    logic [FBW-1:0]   bit_sel;
    logic [4:0]       byte_cnt;
    logic [7:0]       bit_cnt;
    logic [7:0]       nbits;
    logic [2:0]       k_q;
    logic [3:0]       pack;
    logic [7:0]       partial;
    logic [1:0]       pair_q, pair_nxt;
    logic             partial_pend;
    logic             start, last_byte, last_bit, hs, stall, enc_en, data_bit;

    assign start     = (state == IDLE) && rx_valid && !abort;
    assign last_byte = (byte_cnt == 5'(FRAME_BYTES - 1));
    assign hs        = tx_valid && tx_ready;
    assign stall     = (bit_cnt[1:0] == 2'd3) && tx_valid && !tx_ready;
    assign enc_en    = (state == ENCODE) && !stall && !abort;
    assign nbits     = 8'(FBW) + 8'(tail_len(k_q, TAIL_FLUSH));
    assign last_bit  = (bit_cnt == nbits - 8'd1);
    assign busy      = (state != IDLE);

    // Indices past the data select nothing, which yields the zero tail bits.
    assign bit_sel  = {{(FBW-1){1'b0}}, 1'b1} << bit_cnt;
    assign data_bit = |(frame_q & bit_sel);

    conv_enc_core u_core (
        .clk      (clk),
        .rst      (rst),
        .clr      (abort || start),
        .en       (enc_en),
        .k        (k_q),
        .bit_in   (data_bit),
        .pair     (pair_q),
        .pair_nxt (pair_nxt)
    );

    // Slots 0/1 live in pack, the newest slot in pair_q.
    always_comb begin
        case (nbits[1:0])
            2'd1:    partial = {6'b0, pair_q};
            2'd2:    partial = {4'b0, pair_q, pack[1:0]};
            default: partial = {2'b0, pair_q, pack};
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = last_byte ? ENCODE : COLLECT;
            COLLECT: if (rx_valid && last_byte) state_nxt = ENCODE;
            ENCODE:  if (enc_en && last_bit) state_nxt = DRAIN;
            DRAIN:   if (!partial_pend && (hs || !tx_valid)) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (abort)
            state_nxt = IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            frame_q      <= '0;
            byte_cnt     <= '0;
            bit_cnt      <= '0;
            k_q          <= K_MIN;
            pack         <= '0;
            partial_pend <= 1'b0;
            tx_data      <= '0;
            tx_valid     <= 1'b0;
            frame_done   <= 1'b0;
            k_err        <= 1'b0;
            rx_overrun   <= 1'b0;
        end else begin
            frame_done <= (state == DRAIN) && (state_nxt == IDLE) && !abort;

            if (start) begin
                if (k_sel < K_MIN || k_sel > K_MAX) begin
                    k_q   <= K_MIN;
                    k_err <= 1'b1;
                end else begin
                    k_q <= k_sel;
                end
            end

            if (rx_valid && (state == ENCODE || state == DRAIN))
                rx_overrun <= 1'b1;

            if (abort) begin
                byte_cnt     <= '0;
                bit_cnt      <= '0;
                pack         <= '0;
                partial_pend <= 1'b0;
                tx_data      <= '0;
                tx_valid     <= 1'b0;
            end else begin
                if (start || (state == COLLECT && rx_valid)) begin
                    for (int i = 0; i < FRAME_BYTES; i++)
                        if (byte_cnt == 5'(i))
                            frame_q[8*i +: 8] <= rx_data;
                    byte_cnt <= last_byte ? 5'd0 : byte_cnt + 5'd1;
                end

                if (enc_en) begin
                    bit_cnt <= last_bit ? 8'd0 : bit_cnt + 8'd1;
                    case (bit_cnt[1:0])
                        2'd1:    pack[1:0] <= pair_q;
                        2'd2:    pack[3:2] <= pair_q;
                        default: ;
                    endcase
                    if (last_bit)
                        partial_pend <= (nbits[1:0] != 2'd0);
                end

                if (enc_en && bit_cnt[1:0] == 2'd3) begin
                    tx_data  <= {pair_nxt, pair_q, pack};
                    tx_valid <= 1'b1;
                end else if (state == DRAIN && partial_pend && (!tx_valid || tx_ready)) begin
                    tx_data      <= partial;
                    tx_valid     <= 1'b1;
                    partial_pend <= 1'b0;
                end else if (hs) begin
                    tx_valid <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_conv_frame_encoder.sv
// Drives a flushed and an unflushed encoder with identical frames and scores both against a bit-level model.
module tb_conv_frame_encoder;

    logic       clk;
    logic       rst;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic [2:0] k_sel;
    logic       abort;
    logic       tx_ready;
    logic [7:0] tx_data_f, tx_data_n;
    logic       tx_valid_f, tx_valid_n;
    logic       busy_f, busy_n;
    logic       frame_done_f, frame_done_n;
    logic       k_err_f, k_err_n;
    logic       rx_overrun_f, rx_overrun_n;

    int n_checks = 0;
    int n_errors = 0;
    int ready_mode = 0;
    int done_f = 0;
    int done_n = 0;
    logic [7:0] got_f[$], got_n[$], exp_f[$], exp_n[$];
    logic       pend_f = 1'b0, pend_n = 1'b0;
    logic [7:0] pend_dat_f = 8'h0, pend_dat_n = 8'h0;

    conv_frame_encoder #(.FRAME_BYTES(4), .TAIL_FLUSH(1)) dut_f (
        .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data), .k_sel(k_sel),
        .abort(abort), .tx_data(tx_data_f), .tx_valid(tx_valid_f), .tx_ready(tx_ready),
        .busy(busy_f), .frame_done(frame_done_f), .k_err(k_err_f), .rx_overrun(rx_overrun_f)
    );

    conv_frame_encoder #(.FRAME_BYTES(4), .TAIL_FLUSH(0)) dut_n (
        .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data), .k_sel(k_sel),
        .abort(abort), .tx_data(tx_data_n), .tx_valid(tx_valid_n), .tx_ready(tx_ready),
        .busy(busy_n), .frame_done(frame_done_n), .k_err(k_err_n), .rx_overrun(rx_overrun_n)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    function automatic int gen(input int k, input int which);
        case (k)
            3:       return which == 0 ? 'o7  : 'o5;
            4:       return which == 0 ? 'o17 : 'o15;
            5:       return which == 0 ? 'o35 : 'o23;
            default: return which == 0 ? 'o75 : 'o53;
        endcase
    endfunction

    // Straight from the code definition: window bit t holds the input k-1-t steps back.
    function automatic void ref_encode(input logic [31:0] data, input int k, input bit flush);
        int bits[$];
        int w, src, p0, p1, acc;
        for (int i = 0; i < 32; i++) bits.push_back(int'(data[i]));
        if (flush) for (int i = 0; i < k - 1; i++) bits.push_back(0);
        acc = 0;
        for (int n = 0; n < bits.size(); n++) begin
            w = 0;
            for (int t = 0; t < k; t++) begin
                src = n - (k - 1 - t);
                if (src >= 0 && bits[src] == 1) w |= (1 << t);
            end
            p0 = $countones(w & gen(k, 0)) % 2;
            p1 = $countones(w & gen(k, 1)) % 2;
            acc |= (p0 | (p1 << 1)) << (2 * (n % 4));
            if (n % 4 == 3 || n == bits.size() - 1) begin
                if (flush) exp_f.push_back(8'(acc));
                else       exp_n.push_back(8'(acc));
                acc = 0;
            end
        end
    endfunction

    initial begin
        tx_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            tx_ready = (ready_mode == 2) ? 1'($urandom_range(0, 1)) : (ready_mode == 1 ? 1'b0 : 1'b1);
        end
    end

    always @(negedge clk) begin
        if (pend_f) chk_eq("hold_f", {tx_valid_f, tx_data_f}, {1'b1, pend_dat_f});
        if (pend_n) chk_eq("hold_n", {tx_valid_n, tx_data_n}, {1'b1, pend_dat_n});
        pend_f = tx_valid_f && !tx_ready && !abort && !rst;
        pend_n = tx_valid_n && !tx_ready && !abort && !rst;
        pend_dat_f = tx_data_f;
        pend_dat_n = tx_data_n;
        if (tx_valid_f && tx_ready) got_f.push_back(tx_data_f);
        if (tx_valid_n && tx_ready) got_n.push_back(tx_data_n);
        if (frame_done_f) done_f++;
        if (frame_done_n) done_n++;
    end

    task automatic send_frame(input logic [31:0] data, input logic [2:0] ks);
        for (int i = 0; i < 4; i++) begin
            rx_valid = 1'b1;
            rx_data  = data[8*i +: 8];
            k_sel    = (i == 0) ? ks : 3'($urandom);
            tick();
        end
        rx_valid = 1'b0;
        k_sel    = 3'($urandom);
    endtask

    task automatic run_frame(input logic [31:0] data, input logic [2:0] ks, input int rmode, input bit inj_ovr);
        int kk, df0, dn0, cyc;
        kk = (ks < 3'd3 || ks > 3'd6) ? 3 : int'(ks);
        got_f.delete(); got_n.delete(); exp_f.delete(); exp_n.delete();
        ref_encode(data, kk, 1'b0);
        ref_encode(data, kk, 1'b1);
        df0 = done_f;
        dn0 = done_n;
        ready_mode = (rmode == 2) ? 2 : 0;
        send_frame(data, ks);
        if (inj_ovr) begin
            repeat (3) tick();
            rx_valid = 1'b1;
            rx_data  = 8'($urandom);
            tick();
            rx_valid = 1'b0;
        end
        if (rmode == 1) begin
            cyc = 0;
            while (!tx_valid_f && cyc < 50) begin
                tick();
                cyc++;
            end
            chk_eq("first_vld", tx_valid_f, 1);
            ready_mode = 1;
            repeat (20) tick();
            ready_mode = 0;
        end
        cyc = 0;
        while ((done_f == df0 || done_n == dn0) && cyc < 2000) begin
            tick();
            cyc++;
        end
        chk_eq("timeout", cyc < 2000, 1);
        ready_mode = 0;
        repeat (4) tick();
        chk_eq("done_f", done_f - df0, 1);
        chk_eq("done_n", done_n - dn0, 1);
        chk_eq("idle", {busy_f, busy_n}, 0);
        chk_eq("len_n", got_n.size(), 8);
        chk_eq("len_f", got_f.size(), (2 * (32 + kk - 1) + 7) / 8);
        chk_eq("len_ref_f", got_f.size(), exp_f.size());
        for (int i = 0; i < got_n.size() && i < exp_n.size(); i++)
            chk_eq($sformatf("byte_n%0d", i), got_n[i], exp_n[i]);
        for (int i = 0; i < got_f.size() && i < exp_f.size(); i++)
            chk_eq($sformatf("byte_f%0d", i), got_f[i], exp_f[i]);
    endtask

    initial begin
        int cyc, df0;
        rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h0; k_sel = 3'd3; abort = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        chk_eq("rst_f", {tx_data_f, tx_valid_f, busy_f, frame_done_f, k_err_f, rx_overrun_f}, 0);
        chk_eq("rst_n", {tx_data_n, tx_valid_n, busy_n, frame_done_n, k_err_n, rx_overrun_n}, 0);

        run_frame(32'h0000_0001, 3'd3, 0, 1'b0);
        chk_eq("imp_n0", got_n.size() > 0 ? got_n[0] : 8'hxx, 8'h37);
        chk_eq("imp_f8", got_f.size() > 8 ? got_f[8] : 8'hxx, 8'h00);
        run_frame(32'hFFFF_FFFF, 3'd3, 0, 1'b0);
        chk_eq("ones_n0", got_n.size() > 0 ? got_n[0] : 8'hxx, 8'h5B);
        chk_eq("ones_n7", got_n.size() > 7 ? got_n[7] : 8'hxx, 8'h55);

        for (int k = 4; k <= 6; k++) run_frame($urandom, 3'(k), 0, 1'b0);
        run_frame(32'hA5C3_1E77, 3'd5, 1, 1'b0);
        chk_eq("no_ovr", {rx_overrun_f, rx_overrun_n, k_err_f, k_err_n}, 0);

        run_frame(32'h1234_5678, 3'd7, 0, 1'b1);
        chk_eq("k_err", {k_err_f, k_err_n}, 2'b11);
        chk_eq("overrun", {rx_overrun_f, rx_overrun_n}, 2'b11);

        for (int r = 0; r < 6; r++) run_frame($urandom, 3'($urandom_range(3, 6)), 2, 1'b0);

        // Abort mid-ENCODE: nothing further may come out of the old frame.
        df0 = done_f;
        send_frame(32'hDEAD_BEEF, 3'd4);
        cyc = 0;
        while (!tx_valid_f && cyc < 50) begin
            tick();
            cyc++;
        end
        repeat (3) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        tick();
        got_f.delete();
        got_n.delete();
        repeat (60) tick();
        chk_eq("abort_stale", got_f.size() + got_n.size(), 0);
        chk_eq("abort_done", done_f - df0, 0);
        chk_eq("abort_idle", {busy_f, busy_n, tx_valid_f, tx_valid_n}, 0);
        run_frame(32'h0BAD_F00D, 3'd6, 0, 1'b0);

        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        chk_eq("rst_sticky", {k_err_f, k_err_n, rx_overrun_f, rx_overrun_n}, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
